// File: rtl/qpu_dtcm_ram_ctrl.sv
// DTCM SRAM controller: round-robin sharing of the single RAM port between two requesters.
// Define QPU_DTCM_LS_EN to compile in the idle light-sleep / wake sequencer.
module qpu_dtcm_ram_ctrl #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int MW       = 4,
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_cmd_valid,
    output logic          a_cmd_ready,
    input  logic          a_cmd_read,
    input  logic [AW-1:0] a_cmd_addr,
    input  logic [DW-1:0] a_cmd_wdata,
    input  logic [MW-1:0] a_cmd_wmask,
    output logic          a_rsp_valid,
    input  logic          a_rsp_ready,
    output logic [DW-1:0] a_rsp_rdata,
    input  logic          b_cmd_valid,
    output logic          b_cmd_ready,
    input  logic          b_cmd_read,
    input  logic [AW-1:0] b_cmd_addr,
    input  logic [DW-1:0] b_cmd_wdata,
    input  logic [MW-1:0] b_cmd_wmask,
    output logic          b_rsp_valid,
    input  logic          b_rsp_ready,
    output logic [DW-1:0] b_rsp_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd,
    output logic          ctrl_busy
);

    if (IDLE_CYC < 2 || WAKE_CYC < 1) begin : g_bad_cfg
        $error("qpu_dtcm_ram_ctrl: IDLE_CYC must be >= 2 and WAKE_CYC >= 1");
    end

    logic          active;
    logic          a_pend, b_pend, a_first, b_first, a_rd, b_rd, last_b;
    logic [DW-1:0] a_hold, b_hold;
    logic          elig_a, elig_b, grant_a, grant_b;

    assign ram_ds = 1'b0;
    assign ram_sd = 1'b0;

`ifdef QPU_DTCM_LS_EN
    typedef enum logic [1:0] {ST_ACTIVE, ST_SLEEP, ST_WAKE} state_t;
    localparam int CNT_MAX = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          any_valid;

    assign any_valid = a_cmd_valid | b_cmd_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // One counter serves both the idle timeout (ACTIVE) and the wake delay (WAKE).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ACTIVE: begin
                if (any_valid || a_pend || b_pend) begin
                    cnt_nxt = '0;
                end else if (cnt == CW'(IDLE_CYC - 1)) begin
                    state_nxt = ST_SLEEP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_SLEEP: begin
                cnt_nxt = '0;
                if (any_valid) state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (cnt == CW'(WAKE_CYC - 1)) begin
                    state_nxt = ST_ACTIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ACTIVE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign active    = (state == ST_ACTIVE);
    assign ram_ls    = (state == ST_SLEEP);
    assign ctrl_busy = !((state == ST_SLEEP) && !a_pend && !b_pend);
`else
    assign active    = 1'b1;
    assign ram_ls    = 1'b0;
    assign ctrl_busy = a_pend | b_pend | a_cmd_valid | b_cmd_valid;
`endif

    // A port with a pending response may reissue only when that response retires this cycle.
    assign elig_a  = rst_n && active && a_cmd_valid && (!a_pend || a_rsp_ready);
    assign elig_b  = rst_n && active && b_cmd_valid && (!b_pend || b_rsp_ready);
    assign grant_b = elig_b && (!elig_a || !last_b);
    assign grant_a = elig_a && !grant_b;

    assign a_cmd_ready = grant_a;
    assign b_cmd_ready = grant_b;

    always_comb begin
        ram_cs   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wem  = '0;
        ram_din  = '0;
        if (grant_a) begin
            ram_cs   = 1'b1;
            ram_we   = ~a_cmd_read;
            ram_addr = a_cmd_addr;
            ram_wem  = a_cmd_read ? '0 : a_cmd_wmask;
            ram_din  = a_cmd_wdata;
        end else if (grant_b) begin
            ram_cs   = 1'b1;
            ram_we   = ~b_cmd_read;
            ram_addr = b_cmd_addr;
            ram_wem  = b_cmd_read ? '0 : b_cmd_wmask;
            ram_din  = b_cmd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_b  <= 1'b0;
            a_pend  <= 1'b0;
            b_pend  <= 1'b0;
            a_first <= 1'b0;
            b_first <= 1'b0;
            a_rd    <= 1'b0;
            b_rd    <= 1'b0;
            a_hold  <= '0;
            b_hold  <= '0;
        end else begin
            if (grant_a || grant_b) last_b <= grant_b;
            a_first <= grant_a;
            b_first <= grant_b;
            if (grant_a) begin
                a_pend <= 1'b1;
                a_rd   <= a_cmd_read;
            end else if (a_rsp_ready) begin
                a_pend <= 1'b0;
            end
            if (grant_b) begin
                b_pend <= 1'b1;
                b_rd   <= b_cmd_read;
            end else if (b_rsp_ready) begin
                b_pend <= 1'b0;
            end
            // ram_dout is only valid for one cycle, so capture it if the response stalls.
            if (a_pend && a_first && !a_rsp_ready) a_hold <= a_rd ? ram_dout : '0;
            if (b_pend && b_first && !b_rsp_ready) b_hold <= b_rd ? ram_dout : '0;
        end
    end

    assign a_rsp_valid = a_pend;
    assign b_rsp_valid = b_pend;
    assign a_rsp_rdata = !a_pend ? '0 : a_first ? (a_rd ? ram_dout : '0) : a_hold;
    assign b_rsp_rdata = !b_pend ? '0 : b_first ? (b_rd ? ram_dout : '0) : b_hold;

endmodule

// File: tb/tb_qpu_dtcm_ram_ctrl.sv
// Directed self-checking bench for qpu_dtcm_ram_ctrl with a behavioural single-port RAM.
// Sleep/wake checks are included when QPU_DTCM_LS_EN is defined.
module tb_qpu_dtcm_ram_ctrl;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_cmd_valid, a_cmd_ready, a_cmd_read, a_rsp_valid, a_rsp_ready;
    logic [AW-1:0] a_cmd_addr;
    logic [DW-1:0] a_cmd_wdata, a_rsp_rdata;
    logic [MW-1:0] a_cmd_wmask;
    logic          b_cmd_valid, b_cmd_ready, b_cmd_read, b_rsp_valid, b_rsp_ready;
    logic [AW-1:0] b_cmd_addr;
    logic [DW-1:0] b_cmd_wdata, b_rsp_rdata;
    logic [MW-1:0] b_cmd_wmask;
    logic          ram_cs, ram_we, ram_ls, ram_ds, ram_sd, ctrl_busy;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din, ram_dout;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [DW-1:0] mem [0:255];

    qpu_dtcm_ram_ctrl #(
        .AW(AW), .DW(DW), .MW(MW), .IDLE_CYC(16), .WAKE_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_cmd_valid(a_cmd_valid), .a_cmd_ready(a_cmd_ready), .a_cmd_read(a_cmd_read),
        .a_cmd_addr(a_cmd_addr), .a_cmd_wdata(a_cmd_wdata), .a_cmd_wmask(a_cmd_wmask),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_cmd_valid(b_cmd_valid), .b_cmd_ready(b_cmd_ready), .b_cmd_read(b_cmd_read),
        .b_cmd_addr(b_cmd_addr), .b_cmd_wdata(b_cmd_wdata), .b_cmd_wmask(b_cmd_wmask),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_ls(ram_ls), .ram_ds(ram_ds), .ram_sd(ram_sd), .ctrl_busy(ctrl_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int i = 0; i < MW; i++)
                    if (ram_wem[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_din[8*i +: 8];
            end else begin
                ram_dout <= mem[ram_addr[7:0]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_cmd_valid = 0; a_cmd_read = 0; a_cmd_addr = '0; a_cmd_wdata = '0; a_cmd_wmask = '0;
        b_cmd_valid = 0; b_cmd_read = 0; b_cmd_addr = '0; b_cmd_wdata = '0; b_cmd_wmask = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        a_rsp_ready = 1; b_rsp_ready = 1;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic a_drive(input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm);
        a_cmd_valid = 1; a_cmd_read = rd; a_cmd_addr = addr; a_cmd_wdata = wd; a_cmd_wmask = wm;
    endtask

    task automatic b_drive(input logic rd, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm);
        b_cmd_valid = 1; b_cmd_read = rd; b_cmd_addr = addr; b_cmd_wdata = wd; b_cmd_wmask = wm;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h20] = 32'h1234_5678;
        ram_dout = '0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_a_rsp_valid", {31'b0, a_rsp_valid}, 0);
        check("rst_b_rsp_valid", {31'b0, b_rsp_valid}, 0);
        check("rst_ram_cs", {31'b0, ram_cs}, 0);
        check("rst_ram_ls", {31'b0, ram_ls}, 0);
        check("rst_ds_sd", {30'b0, ram_ds, ram_sd}, 0);
`ifdef QPU_DTCM_LS_EN
        check("rst_busy", {31'b0, ctrl_busy}, 1);
`else
        check("rst_busy", {31'b0, ctrl_busy}, 0);
`endif

        // back-to-back write then read on port A
        #1;
        a_drive(0, 16'h0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        check("wr_a_ready", {31'b0, a_cmd_ready}, 1);
        check("wr_ram_pins", {ram_cs, ram_we, ram_wem, 10'b0, ram_addr}, {1'b1, 1'b1, 4'hF, 10'b0, 16'h0010});
        check("wr_ram_din", ram_din, 32'hDEAD_BEEF);
        check("wr_busy", {31'b0, ctrl_busy}, 1);
        tick();
        a_drive(1, 16'h0010, 32'h0, 4'hF);
        @(negedge clk);
        check("rd_a_ready_b2b", {31'b0, a_cmd_ready}, 1);
        check("rd_ram_we_wem", {27'b0, ram_cs, ram_we, ram_wem}, {27'b0, 1'b1, 1'b0, 4'h0});
        check("wr_rsp_valid", {31'b0, a_rsp_valid}, 1);
        check("wr_rsp_rdata", a_rsp_rdata, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("rd_rsp_valid", {31'b0, a_rsp_valid}, 1);
        check("rd_rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
        tick();
        // partial-mask write to 0x11 (initially 0) then read back
        a_drive(0, 16'h0011, 32'hAABB_CCDD, 4'h3);
        @(negedge clk);
        check("rd_rsp_retired", {31'b0, a_rsp_valid}, 0);
        tick();
        a_drive(1, 16'h0011, 32'h0, 4'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("mask_rdata", a_rsp_rdata, 32'h0000_CCDD);
        tick();

        // contention: first grant goes to B after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_drive(1, 16'h0010, 32'h0, 4'h0);
            b_drive(1, 16'h0020, 32'h0, 4'h0);
            @(negedge clk);
            check($sformatf("rr_grant_%0d", i), {30'b0, a_cmd_ready, b_cmd_ready},
                  (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) begin
                if (i % 2 == 0) check($sformatf("rr_a_rdata_%0d", i), a_rsp_rdata, 32'hDEAD_BEEF);
                else            check($sformatf("rr_b_rdata_%0d", i), b_rsp_rdata, 32'h1234_5678);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("rr_last_a_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
        tick();

        // response backpressure on B while A rewrites the word B read
        b_rsp_ready = 0;
        b_drive(1, 16'h0020, 32'h0, 4'h0);
        @(negedge clk);
        check("bp_b_grant", {31'b0, b_cmd_ready}, 1);
        tick();
        b_drive(1, 16'h0010, 32'h0, 4'h0);
        a_drive(0, 16'h0020, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        check("bp_c2_ready", {30'b0, a_cmd_ready, b_cmd_ready}, 32'd2);
        check("bp_c2_rdata", b_rsp_rdata, 32'h1234_5678);
        tick();
        a_drive(1, 16'h0020, 32'h0, 4'h0);
        @(negedge clk);
        check("bp_c3_ready", {30'b0, a_cmd_ready, b_cmd_ready}, 32'd2);
        check("bp_c3_rdata", b_rsp_rdata, 32'h1234_5678);
        tick();
        a_cmd_valid = 0;
        @(negedge clk);
        check("bp_c4_b_ready", {31'b0, b_cmd_ready}, 0);
        check("bp_c4_a_rdata", a_rsp_rdata, 32'hCAFE_F00D);
        check("bp_c4_b_rdata", b_rsp_rdata, 32'h1234_5678);
        check("bp_c4_b_valid", {31'b0, b_rsp_valid}, 1);
        tick();
        b_rsp_ready = 1;
        @(negedge clk);
        check("bp_c5_b_ready", {31'b0, b_cmd_ready}, 1);
        check("bp_c5_b_rdata", b_rsp_rdata, 32'h1234_5678);
        tick();
        idle_inputs();
        @(negedge clk);
        check("bp_c6_b_rdata", b_rsp_rdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("bp_c7_b_valid", {31'b0, b_rsp_valid}, 0);
        #1;

        // reset in the cycle after a read grant
        a_drive(1, 16'h0010, 32'h0, 4'h0);
        tick();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        check("mr_valid_before_edge", {31'b0, a_rsp_valid}, 1);
        tick();
        rst_n = 1;
        @(negedge clk);
        check("mr_valid_after_edge", {31'b0, a_rsp_valid}, 0);
        check("mr_rdata_after_edge", a_rsp_rdata, 32'h0);
        #1;
        a_drive(1, 16'h0020, 32'h0, 4'h0);
        @(negedge clk);
        check("mr_regrant", {31'b0, a_cmd_ready}, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("mr_fresh_rdata", a_rsp_rdata, 32'hCAFE_F00D);
        tick();

`ifdef QPU_DTCM_LS_EN
        // sleep entry after 16 idle cycles, then wake
        do_reset();
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("ls_cycle16", {31'b0, ram_ls}, 0);
        @(negedge clk);
        check("ls_entered", {31'b0, ram_ls}, 1);
        check("ls_busy", {31'b0, ctrl_busy}, 0);
        #1;
        a_drive(1, 16'h0010, 32'h0, 4'h0);
        @(negedge clk);
        check("wk_s0", {30'b0, ram_ls, a_cmd_ready}, 32'd2);
        @(negedge clk);
        check("wk_s1", {30'b0, ram_ls, a_cmd_ready}, 32'd0);
        @(negedge clk);
        check("wk_s2", {30'b0, ram_ls, a_cmd_ready}, 32'd0);
        @(negedge clk);
        check("wk_s3_grant", {30'b0, ram_ls, a_cmd_ready}, 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("wk_rdata", a_rsp_rdata, 32'hDEAD_BEEF);

        // command on the 16th idle cycle: no sleep, same-cycle grant
        do_reset();
        repeat (15) @(posedge clk);
        #1;
        a_drive(1, 16'h0020, 32'h0, 4'h0);
        @(negedge clk);
        check("bd_grant", {31'b0, a_cmd_ready}, 1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("bd_no_sleep", {30'b0, ram_ls, a_rsp_valid}, 32'd1);
        check("bd_rdata", a_rsp_rdata, 32'hCAFE_F00D);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
